// File: rtl/cordic_phase.sv
// cordic_phase: iterative vectoring CORDIC, (I,Q) -> phase (2^wph = 2pi), magnitude.
// Optional `CORDIC_GAIN_COMP_EN adds a GAIN state that removes the CORDIC gain.
module cordic_phase #(
   parameter int width = 17,
   parameter int wph   = 17,
   parameter int nstg  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sync_in,
   input  logic signed [width-1:0] i_in,
   input  logic signed [width-1:0] q_in,
   output logic                    busy,
   output logic                    sync_out,
   output logic signed [wph-1:0]   phase_out,
   output logic        [width:0]   mag_out,
   output logic                    overrun
);

   localparam int XW  = width + 2;
   localparam int ZW  = wph + 2;
   localparam int KW  = $clog2(nstg);
   localparam int RSH = 32 - ZW;
   localparam logic [32:0] RND = (33'd1 << RSH) >> 1;

   // atan(2^-k) as a fraction of a full turn, 2^32 = 2pi
   localparam logic [31:0] ATAN_TBL [32] = '{
      32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
      32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
      32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
      32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
      32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
      32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
      32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
   };

   typedef enum logic [2:0] {
      S_IDLE,
      S_FOLD,
      S_ITER,
      S_GAIN,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic signed [XW-1:0]    x_q, x_d;
   logic signed [XW-1:0]    y_q, y_d;
   logic        [ZW-1:0]    z_q, z_d;
   logic        [KW-1:0]    k_q, k_d;
   logic                    zero_q, zero_d;
   logic                    sync_q, sync_d;
   logic                    ovr_q, ovr_d;
   logic signed [wph-1:0]   ph_q, ph_d;
   logic        [width:0]   mag_q, mag_d;

   logic signed [XW-1:0]    xs;
   logic signed [XW-1:0]    ys;
   logic        [ZW-1:0]    atan_k;

   assign xs     = x_q >>> k_q;
   assign ys     = y_q >>> k_q;
   assign atan_k = ZW'(({1'b0, ATAN_TBL[k_q]} + RND) >> RSH);

`ifdef CORDIC_GAIN_COMP_EN
   localparam logic [16:0] GAIN_K = 17'd39797;
   logic [XW+16:0] prod;
   assign prod = {17'd0, x_q} * {{XW{1'b0}}, GAIN_K};
`endif

   assign busy      = (state_q != S_IDLE) | sync_q;
   assign sync_out  = sync_q;
   assign phase_out = ph_q;
   assign mag_out   = mag_q;
   assign overrun   = ovr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         k_q     <= '0;
         zero_q  <= 1'b0;
         sync_q  <= 1'b0;
         ovr_q   <= 1'b0;
         ph_q    <= '0;
         mag_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         k_q     <= k_d;
         zero_q  <= zero_d;
         sync_q  <= sync_d;
         ovr_q   <= ovr_d;
         ph_q    <= ph_d;
         mag_q   <= mag_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      k_d     = k_q;
      zero_d  = zero_q;
      sync_d  = 1'b0;
      ovr_d   = ovr_q | (sync_in & busy);
      ph_d    = ph_q;
      mag_d   = mag_q;
      unique case (state_q)
         S_IDLE: begin
            if (sync_in && !sync_q) begin
               x_d     = {{2{i_in[width-1]}}, i_in};
               y_d     = {{2{q_in[width-1]}}, q_in};
               zero_d  = (i_in == '0) && (q_in == '0);
               state_d = S_FOLD;
            end
         end
         S_FOLD: begin
            if (x_q[XW-1]) begin
               x_d = -x_q;
               y_d = -y_q;
               z_d = {1'b1, {(ZW-1){1'b0}}};
            end else begin
               z_d = '0;
            end
            k_d     = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            if (!y_q[XW-1]) begin
               x_d = x_q + ys;
               y_d = y_q - xs;
               z_d = z_q + atan_k;
            end else begin
               x_d = x_q - ys;
               y_d = y_q + xs;
               z_d = z_q - atan_k;
            end
            k_d = k_q + KW'(1);
            if (k_q == KW'(nstg - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
               state_d = S_GAIN;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef CORDIC_GAIN_COMP_EN
         S_GAIN: begin
            x_d     = XW'((prod + (XW+17)'(32768)) >> 16);
            state_d = S_DONE;
         end
`endif
         S_DONE: begin
            // a zero vector has no angle; report 0 instead of the atan sum
            if (zero_q) begin
               ph_d = '0;
            end else begin
               ph_d = wph'((z_q + ZW'(2)) >> 2);
            end
            if (x_q[XW-1]) begin
               mag_d = '0;
            end else begin
               mag_d = x_q[XW-2:0];
            end
            sync_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
